// File: rtl/video_pattern_pkg.sv
// Shared constants and helpers for the video test-pattern generator.
package video_pattern_pkg;

  localparam logic [2:0] PAT_BITWALK = 3'd0;
  localparam logic [2:0] PAT_BARS    = 3'd1;
  localparam logic [2:0] PAT_RAMP    = 3'd2;
  localparam logic [2:0] PAT_CHECK   = 3'd3;
  localparam logic [2:0] PAT_SCROLL  = 3'd4;

  localparam int FRAME_CNT_W = 16;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // Classic 8-bar sequence: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_colour(input logic [2:0] k);
    return {~k[1], ~k[2], ~k[0]};
  endfunction

endpackage

// File: rtl/bar_seg_counter.sv
// Division-free bar position tracker: pixel-within-bar and bar index.
module bar_seg_counter #(
  parameter int BAR_W   = 8,
  parameter int BAR_NUM = 8,
  parameter int SEG_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1,
  parameter int IDX_W   = $clog2(BAR_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic             wrap_i,
  input  logic [SEG_W-1:0] load_seg_i,
  input  logic [IDX_W-1:0] load_idx_i,
  output logic [IDX_W-1:0] idx_o
);

  logic [SEG_W-1:0] seg_q;
  logic [IDX_W-1:0] idx_q;

  // NOTE: sequential state is assigned with <= only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      seg_q <= load_seg_i;
      idx_q <= load_idx_i;
    end else if (adv_i) begin
      if (seg_q == SEG_W'(BAR_W - 1)) begin
        seg_q <= '0;
        // Saturating on the last bar lets remainder pixels join it; wrap is for scrolling.
        if (idx_q == IDX_W'(BAR_NUM - 1))
          idx_q <= wrap_i ? '0 : idx_q;
        else
          idx_q <= idx_q + IDX_W'(1);
      end else begin
        seg_q <= seg_q + SEG_W'(1);
      end
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern source between the timing generator and the DVI transmitter.
// Two-stage pipeline: stage 1 holds counters/indices, stage 2 holds colour.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE    = 1920,
  parameter int V_ACTIVE    = 1080,
  parameter int BAR_NUM     = 16,
  parameter int CW          = 8,
  parameter int CHK_LOG2    = 5,
  parameter int SCROLL_STEP = 1
) (
  input  logic                   rgb_clk,
  input  logic                   rgb_rst,
  input  logic [2:0]             mode,
  input  logic                   in_hs,
  input  logic                   in_vs,
  input  logic                   in_de,
  output logic                   out_hs,
  output logic                   out_vs,
  output logic                   out_de,
  output logic [CW-1:0]          out_r,
  output logic [CW-1:0]          out_g,
  output logic [CW-1:0]          out_b,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int BAR_W = H_ACTIVE / BAR_NUM;
  localparam int XY_W  = $clog2((H_ACTIVE > V_ACTIVE) ? H_ACTIVE : V_ACTIVE);
  localparam int SEG_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int IDX_W = $clog2(BAR_NUM);
  localparam int RGB_W = 3 * CW;
  localparam logic [RGB_W-1:0] WALK_MSB = {1'b1, {(RGB_W-1){1'b0}}};

  sync_t                  s1_q, s2_q;
  logic [XY_W-1:0]        x_q, y_q;
  logic [2:0]             act_mode_q;
  logic [FRAME_CNT_W-1:0] frame_q;
  logic [IDX_W-1:0]       start_idx_q, start_idx_d, bar_idx;
  logic [SEG_W-1:0]       start_seg_q, start_seg_d;
  logic [SEG_W:0]         seg_sum;
  logic [RGB_W-1:0]       rgb_q, rgb_d;
  logic [2:0]             bar_rgb;
  logic                   vs_rise, de_rise, de_fall, scroll, chk;

  assign vs_rise = in_vs & ~s1_q.vs;
  assign de_rise = in_de & ~s1_q.de;
  assign de_fall = ~in_de & s1_q.de;
  assign scroll  = (act_mode_q == PAT_SCROLL);

  // Scroll offset advance with carry from pixel-in-bar into bar index.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    seg_sum     = {1'b0, start_seg_q} + (SEG_W+1)'(SCROLL_STEP);
    start_seg_d = SEG_W'(seg_sum);
    start_idx_d = start_idx_q;
    if (seg_sum >= (SEG_W+1)'(BAR_W)) begin
      start_seg_d = SEG_W'(seg_sum - (SEG_W+1)'(BAR_W));
      start_idx_d = (start_idx_q == IDX_W'(BAR_NUM - 1)) ? '0 : start_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge rgb_clk or posedge rgb_rst) begin
    if (rgb_rst) begin
      s1_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      act_mode_q  <= PAT_BITWALK;
      frame_q     <= '0;
      start_idx_q <= '0;
      start_seg_q <= '0;
    end else begin
      s1_q <= '{hs: in_hs, vs: in_vs, de: in_de};
      if (in_de)
        x_q <= de_rise ? '0 : x_q + XY_W'(1);
      if (vs_rise) begin
        act_mode_q  <= mode;
        frame_q     <= frame_q + FRAME_CNT_W'(1);
        y_q         <= '0;
        start_idx_q <= start_idx_d;
        start_seg_q <= start_seg_d;
      end else if (de_fall) begin
        y_q <= y_q + XY_W'(1);
      end
    end
  end

  bar_seg_counter #(
    .BAR_W   (BAR_W),
    .BAR_NUM (BAR_NUM),
    .SEG_W   (SEG_W),
    .IDX_W   (IDX_W)
  ) u_bar_cnt (
    .clk        (rgb_clk),
    .rst        (rgb_rst),
    .load_i     (de_rise),
    .adv_i      (in_de & s1_q.de),
    .wrap_i     (scroll),
    .load_seg_i (scroll ? start_seg_q : '0),
    .load_idx_i (scroll ? start_idx_q : '0),
    .idx_o      (bar_idx)
  );

  assign bar_rgb = bar_colour(3'(bar_idx));
  assign chk     = 1'((x_q ^ y_q) >> CHK_LOG2);

  always_comb begin
    rgb_d = '0;
    if (s1_q.de) begin
      case (act_mode_q)
        PAT_BITWALK:       rgb_d = WALK_MSB >> (int'(bar_idx) % RGB_W);
        PAT_BARS,
        PAT_SCROLL:        rgb_d = {{CW{bar_rgb[2]}}, {CW{bar_rgb[1]}}, {CW{bar_rgb[0]}}};
        PAT_RAMP:          rgb_d = {3{CW'(x_q)}};
        PAT_CHECK:         rgb_d = chk ? '0 : '1;
        default:           rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge rgb_clk or posedge rgb_rst) begin
    if (rgb_rst) begin
      s2_q  <= '0;
      rgb_q <= '0;
    end else begin
      s2_q  <= s1_q;
      rgb_q <= rgb_d;
    end
  end

  assign out_hs               = s2_q.hs;
  assign out_vs               = s2_q.vs;
  assign out_de               = s2_q.de;
  assign {out_r, out_g, out_b} = rgb_q;
  assign frame_cnt            = frame_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench: two generator configurations share one timing stream.
module tb_video_pattern_gen;

  logic       clk, rgb_rst;
  logic [2:0] mode;
  logic       in_hs, in_vs, in_de;

  logic       a_hs, a_vs, a_de, b_hs, b_vs, b_de;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic [15:0] a_fc, b_fc;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] q_a[$];
  logic [23:0] q_b[$];
  logic [2:0]  h1, h2;

  int act_m = 0, fcnt = 0, y_line = 0, ofs_a = 0, ofs_b = 0;

  // A: 64 px, 16 bars of 4, step 1.  B: 70 px, 8 bars of 8 (6 remainder), step 2.
  video_pattern_gen #(.H_ACTIVE(64), .V_ACTIVE(100), .BAR_NUM(16), .CW(8),
                      .CHK_LOG2(5), .SCROLL_STEP(1)) u_a (
    .rgb_clk(clk), .rgb_rst(rgb_rst), .mode(mode),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .out_hs(a_hs), .out_vs(a_vs), .out_de(a_de),
    .out_r(a_r), .out_g(a_g), .out_b(a_b), .frame_cnt(a_fc));

  video_pattern_gen #(.H_ACTIVE(70), .V_ACTIVE(100), .BAR_NUM(8), .CW(8),
                      .CHK_LOG2(5), .SCROLL_STEP(2)) u_b (
    .rgb_clk(clk), .rgb_rst(rgb_rst), .mode(mode),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .out_hs(b_hs), .out_vs(b_vs), .out_de(b_de),
    .out_r(b_r), .out_g(b_g), .out_b(b_b), .frame_cnt(b_fc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference colour from pixel coordinates, using plain division.
  function automatic logic [23:0] exp_rgb(input int bar_num, input int bar_w, input int m,
                                          input int x, input int y, input int ofs);
    int b;
    logic [2:0] k;
    logic [7:0] v;
    b = x / bar_w;
    if (b > bar_num - 1) b = bar_num - 1;
    case (m)
      0: return 24'h800000 >> (b % 24);
      1, 4: begin
        if (m == 4) b = ((ofs + x) % (bar_num * bar_w)) / bar_w;
        k = b[2:0];
        return {{8{~k[1]}}, {8{~k[2]}}, {8{~k[0]}}};
      end
      2: begin
        v = x[7:0];
        return {v, v, v};
      end
      3: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pixel(input int x);
    q_a.push_back(exp_rgb(16, 4, act_m, x, y_line, ofs_a));
    q_b.push_back(exp_rgb(8, 8, act_m, x, y_line, ofs_b));
  endtask

  // Frame start; the new mode is applied in the very cycle in_vs rises.
  task automatic vs_pulse(input logic [2:0] m);
    tick();
    in_vs = 1'b1;
    mode  = m;
    act_m = m;
    fcnt  = (fcnt + 1) % 65536;
    y_line = 0;
    ofs_a = (ofs_a + 1) % 64;
    ofs_b = (ofs_b + 2) % 64;
    tick();
    tick();
    in_vs = 1'b0;
    tick();
    tick();
    check("frame_cnt_a", a_fc, fcnt);
    check("frame_cnt_b", b_fc, fcnt);
  endtask

  task automatic line(input int n, input int chg_at, input logic [2:0] chg_mode);
    tick(); in_hs = 1'b1;
    tick(); in_hs = 1'b0;
    tick();
    for (int x = 0; x < n; x++) begin
      tick();
      in_de = 1'b1;
      if (x == chg_at) mode = chg_mode;
      push_pixel(x);
    end
    tick();
    in_de = 1'b0;
    y_line++;
    tick();
    tick();
  endtask

  // Monitor: pops the scoreboard on every output pixel and checks the sync delay.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rgb_rst) begin
      h1 = 3'b000;
      h2 = 3'b000;
    end else begin
      check("a_sync_delay", {a_hs, a_vs, a_de}, h2);
      check("b_sync_delay", {b_hs, b_vs, b_de}, h2);
      h2 = h1;
      h1 = {in_hs, in_vs, in_de};
      if (a_de) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL a_underflow: got pixel with empty scoreboard at %0t", $time);
        end else begin
          e = q_a.pop_front();
          check("a_rgb", {a_r, a_g, a_b}, e);
        end
      end else begin
        check("a_blank_rgb", {a_r, a_g, a_b}, 24'h0);
      end
      if (b_de) begin
        if (q_b.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_underflow: got pixel with empty scoreboard at %0t", $time);
        end else begin
          e = q_b.pop_front();
          check("b_rgb", {b_r, b_g, b_b}, e);
        end
      end else begin
        check("b_blank_rgb", {b_r, b_g, b_b}, 24'h0);
      end
    end
  end

  initial begin
    rgb_rst = 1'b1;
    mode  = 3'd0;
    in_hs = 1'b0;
    in_vs = 1'b0;
    in_de = 1'b0;
    #12;
    check("rst_a_outs", {a_hs, a_vs, a_de, a_r, a_g, a_b}, 27'h0);
    check("rst_b_outs", {b_hs, b_vs, b_de, b_r, b_g, b_b}, 27'h0);
    check("rst_a_fc", a_fc, 16'h0);
    check("rst_b_fc", b_fc, 16'h0);
    tick();
    rgb_rst = 1'b0;

    // Before any frame start the latched mode is still bit-walk.
    mode = 3'd1;
    line(64, -1, 3'd0);

    vs_pulse(3'd0);
    line(70, -1, 3'd0);
    line(70, -1, 3'd0);

    // Colour bars; mode input switches to checker mid-way through line 5.
    vs_pulse(3'd1);
    for (int l = 0; l < 7; l++) line(70, (l == 5) ? 20 : -1, 3'd3);

    vs_pulse(3'd3);
    for (int l = 0; l < 36; l++) line(70, -1, 3'd0);

    // Mode change coincident with the vsync edge, then 1-cycle DE/HS pulse latency.
    vs_pulse(3'd2);
    tick();
    in_de = 1'b1;
    in_hs = 1'b1;
    push_pixel(0);
    tick();
    in_de = 1'b0;
    in_hs = 1'b0;
    y_line++;
    check("lat_a_early", {a_hs, a_de}, 2'b00);
    tick();
    check("lat_a_on", {a_hs, a_de}, 2'b11);
    check("lat_b_on", {b_hs, b_de}, 2'b11);
    tick();
    check("lat_a_off", {a_hs, a_de}, 2'b00);
    line(3, -1, 3'd0);
    line(70, -1, 3'd0);

    vs_pulse(3'd5);
    line(70, -1, 3'd0);

    // Reset in the middle of a colour-bar line.
    vs_pulse(3'd1);
    tick(); in_hs = 1'b1;
    tick(); in_hs = 1'b0;
    tick();
    for (int x = 0; x < 20; x++) begin
      tick();
      in_de = 1'b1;
      push_pixel(x);
    end
    @(posedge clk);
    #3;
    check("pre_rst_de", {a_de, b_de}, 2'b11);
    rgb_rst = 1'b1;
    #1;
    check("async_rst_a", {a_hs, a_vs, a_de, a_r, a_g, a_b}, 27'h0);
    check("async_rst_b", {b_hs, b_vs, b_de, b_r, b_g, b_b}, 27'h0);
    check("async_rst_fc", {a_fc, b_fc}, 32'h0);
    in_de = 1'b0;
    q_a.delete();
    q_b.delete();
    act_m = 0; fcnt = 0; y_line = 0; ofs_a = 0; ofs_b = 0;
    tick();
    tick();
    rgb_rst = 1'b0;
    tick();
    check("post_rst_fc", {a_fc, b_fc}, 32'h0);
    mode = 3'd4;
    line(70, -1, 3'd0);

    // Scrolling bars over four frame starts (B offsets 2, 4, 6, 8).
    for (int f = 0; f < 4; f++) begin
      vs_pulse(3'd4);
      line(70, -1, 3'd0);
    end

    repeat (4) tick();
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
